// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, one-hot status codes and
// the memory-stage access state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_BUSY,
        MS_DONE
    } mem_state_t;

    function automatic logic is_rd_op(input logic [3:0] ic);
        return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
    endfunction

    function automatic logic is_wr_op(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
    endfunction

    // ret and popq address the stack through valA; everything else uses valE
    function automatic logic uses_val_a(input logic [3:0] ic);
        return (ic == I_RET) || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 64-bit data memory: synchronous write, combinational read.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage with multi-cycle data memory and stall handshake.
// Define DMEM_PERF_CNT_EN to add read/write/stall performance counters.
module mem_stage
    import y86_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    output logic [3:0]  m_stat,
    output logic [3:0]  m_icode,
    output logic [63:0] m_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_dstE,
    output logic [3:0]  m_dstM,
    output logic        m_stall
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_rd,
    output logic [31:0] perf_wr,
    output logic [31:0] perf_stall
`endif
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [63:0] ADDR_LIM = 64'(8 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(MEM_LAT - 1);

    mem_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   valm_q, valm_d;

    logic          is_rd, is_wr, is_mem;
    logic [63:0]   addr;
    logic          addr_ok, qual, commit, we;
    logic [IW-1:0] idx;
    logic [63:0]   rdata;
    logic          stall_raw;

    always_comb begin
        is_rd   = is_rd_op(M_icode);
        is_wr   = is_wr_op(M_icode);
        is_mem  = is_rd | is_wr;
        addr    = uses_val_a(M_icode) ? M_valA : M_valE;
        addr_ok = (addr[2:0] == 3'b000) && (addr < ADDR_LIM);
        qual    = is_mem && (M_stat == STAT_AOK) && addr_ok;
        idx     = addr[IW+2:3];
        commit  = (state_q == MS_BUSY) && (cnt_q == 4'd0);
        we      = commit & is_wr;
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_dmem (
        .clk   (clk),
        .we    (we),
        .idx   (idx),
        .wdata (M_valA),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= 4'd0;
            valm_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valm_d  = valm_q;
        unique case (state_q)
            MS_IDLE: begin
                if (qual) begin
                    state_d = MS_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MS_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = MS_DONE;
                    if (is_rd) begin
                        valm_d = rdata;
                    end
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        m_stat    = M_stat;
        m_icode   = M_icode;
        m_valE    = M_valE;
        m_dstE    = M_dstE;
        m_dstM    = M_dstM;
        m_valM    = 64'd0;
        stall_raw = 1'b0;
        if (is_mem && (M_stat == STAT_AOK) && !addr_ok) begin
            m_stat = STAT_ADR;
        end
        unique case (state_q)
            MS_IDLE: stall_raw = qual;
            MS_BUSY: stall_raw = 1'b1;
            MS_DONE: m_valM = is_rd ? valm_q : 64'd0;
            default: stall_raw = 1'b0;
        endcase
        // a held reset must not request a stall for the instruction on M
        m_stall = stall_raw & ~rst;
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] prd_q, prd_d;
    logic [31:0] pwr_q, pwr_d;
    logic [31:0] pst_q, pst_d;

    always_comb begin
        prd_d = prd_q + {31'd0, commit & is_rd};
        pwr_d = pwr_q + {31'd0, we};
        pst_d = pst_q + {31'd0, m_stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prd_q <= 32'd0;
            pwr_q <= 32'd0;
            pst_q <= 32'd0;
        end else begin
            prd_q <= prd_d;
            pwr_q <= pwr_d;
            pst_q <= pst_d;
        end
    end

    assign perf_rd    = prd_q;
    assign perf_wr    = pwr_q;
    assign perf_stall = pst_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected results queued at issue,
// compared when the stage releases the instruction.
module tb_mem_stage;
    import y86_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NST   = LAT + 1;

    logic        clk;
    logic        rst;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  m_stat, m_icode, m_dstE, m_dstM;
    logic [63:0] m_valE, m_valM;
    logic        m_stall;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_rd, perf_wr, perf_stall;
`endif

    mem_stage #(
        .DEPTH   (DEPTH),
        .MEM_LAT (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .M_stat  (M_stat),
        .M_icode (M_icode),
        .M_valE  (M_valE),
        .M_valA  (M_valA),
        .M_dstE  (M_dstE),
        .M_dstM  (M_dstM),
        .m_stat  (m_stat),
        .m_icode (m_icode),
        .m_valE  (m_valE),
        .m_valM  (m_valM),
        .m_dstE  (m_dstE),
        .m_dstM  (m_dstM),
        .m_stall (m_stall)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_rd    (perf_rd),
        .perf_wr    (perf_wr),
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valm;
        logic [63:0] vale;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] model [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        M_stat  = STAT_AOK;
        M_icode = I_NOP;
        M_valE  = 64'd0;
        M_valA  = 64'd0;
        M_dstE  = 4'hF;
        M_dstM  = 4'hF;
    endtask

    // called at a negedge; returns at the following negedge with a bubble on M
    task automatic run_op(input logic [3:0] st, input logic [3:0] ic,
                          input logic [63:0] ve, input logic [63:0] va,
                          input logic [3:0] xst, input logic [63:0] xvm,
                          input int xstall);
        exp_t e;
        exp_t g;
        int   n;
        M_stat  = st;
        M_icode = ic;
        M_valE  = ve;
        M_valA  = va;
        M_dstE  = 4'($urandom_range(0, 15));
        M_dstM  = 4'($urandom_range(0, 15));
        e.stat   = xst;
        e.icode  = ic;
        e.valm   = xvm;
        e.vale   = ve;
        e.dste   = M_dstE;
        e.dstm   = M_dstM;
        e.stalls = xstall;
        exp_q.push_back(e);
        #1;
        n = 0;
        while (m_stall && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        g = exp_q.pop_front();
        chk("stall_cycles", 64'(n), 64'(g.stalls));
        chk("m_stat", 64'(m_stat), 64'(g.stat));
        chk("m_icode", 64'(m_icode), 64'(g.icode));
        chk("m_valM", m_valM, g.valm);
        chk("m_valE", m_valE, g.vale);
        chk("m_dstE", 64'(m_dstE), 64'(g.dste));
        chk("m_dstM", 64'(m_dstM), 64'(g.dstm));
        @(posedge clk);
        @(negedge clk);
        bubble();
    endtask

    task automatic store(input logic [3:0] ic, input logic [63:0] a,
                         input logic [63:0] d);
        if (ic == I_RMMOVQ) run_op(STAT_AOK, ic, a, d, STAT_AOK, 64'd0, NST);
        else                run_op(STAT_AOK, ic, a, d, STAT_AOK, 64'd0, NST);
        model[int'(a >> 3)] = d;
    endtask

    task automatic load(input logic [3:0] ic, input logic [63:0] a);
        logic [63:0] x;
        x = model.exists(int'(a >> 3)) ? model[int'(a >> 3)] : 64'd0;
        if (ic == I_MRMOVQ) run_op(STAT_AOK, ic, a, 64'h0, STAT_AOK, x, NST);
        else                run_op(STAT_AOK, ic, 64'h0, a, STAT_AOK, x, NST);
    endtask

    initial begin
        logic [63:0] top;
        logic [63:0] d;
        top = 64'(8 * DEPTH);
        rst = 1'b1;
        bubble();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 64'(m_stall), 64'd0);
        chk("rst_valM", m_valM, 64'd0);
        chk("rst_stat", 64'(m_stat), 64'(STAT_AOK));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        store(I_RMMOVQ, 64'h40, 64'hDEADBEEF);
        load(I_MRMOVQ, 64'h40);
`ifdef DMEM_PERF_CNT_EN
        chk("perf_wr", 64'(perf_wr), 64'd1);
        chk("perf_rd", 64'(perf_rd), 64'd1);
        chk("perf_stall", 64'(perf_stall), 64'(2 * NST));
`endif
        // misaligned popq, out-of-range load: ADR without an access
        run_op(STAT_AOK, I_POPQ, 64'h0, 64'h43, STAT_ADR, 64'd0, 0);
        run_op(STAT_AOK, I_MRMOVQ, top, 64'h0, STAT_ADR, 64'd0, 0);
        run_op(STAT_AOK, I_RMMOVQ, 64'h41, 64'h77, STAT_ADR, 64'd0, 0);
        run_op(STAT_AOK, 4'h6, 64'h1234, 64'h5, STAT_AOK, 64'd0, 0);
        run_op(STAT_AOK, I_NOP, 64'hABCD, 64'h0, STAT_AOK, 64'd0, 0);
        // non-AOK store is suppressed and leaves memory untouched
        run_op(STAT_HLT, I_RMMOVQ, 64'h40, 64'hBAD, STAT_HLT, 64'd0, 0);
        run_op(STAT_INS, I_MRMOVQ, 64'h40, 64'h0, STAT_INS, 64'd0, 0);
        load(I_MRMOVQ, 64'h40);

        store(I_RMMOVQ, top - 64'd8, 64'hCAFE_F00D_1234_5678);
        load(I_POPQ, top - 64'd8);
        store(I_CALL, 64'h80, 64'h1111);
        load(I_RET, 64'h80);

        // reset while a pushq to 0x80 is in flight: no commit
        M_stat  = STAT_AOK;
        M_icode = I_PUSHQ;
        M_valE  = 64'h80;
        M_valA  = 64'h2222;
        M_dstE  = 4'h4;
        M_dstM  = 4'hF;
        #1;
        chk("push_stall", 64'(m_stall), 64'd1);
        @(posedge clk);
        #1;
        chk("busy_stall", 64'(m_stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall", 64'(m_stall), 64'd0);
        chk("abort_valM", m_valM, 64'd0);
        chk("abort_valE", m_valE, 64'h80);
        @(posedge clk);
        @(negedge clk);
        bubble();
`ifdef DMEM_PERF_CNT_EN
        chk("perf_clr", 64'(perf_stall), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(I_MRMOVQ, 64'h80);

        // back-to-back random stores then loads
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            store(I_PUSHQ, 64'h200 + 64'(8 * i), d);
        end
        for (int i = 0; i < 4; i++) begin
            load(I_MRMOVQ, 64'h200 + 64'(8 * i));
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the Y86-64 pipeline: the consumer of the execute→memory pipeline register outputs (M_*).
- Performs data-memory reads and writes against an internal word-addressed data memory with a configurable multi-cycle latency.
- Produces m_* results for the writeback register and forwarding logic.
- Raises m_stall so the hazard unit holds the M register and bubbles W while an access is in flight.

Parameters:
- DEPTH, 1024, number of 64-bit data-memory words; byte address range 0 .. 8*DEPTH-1.
- MEM_LAT, 2, access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- M_stat  in  4  status from M register (one-hot: AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001).
- M_icode  in  4  instruction code from M register.
- M_valE  in  64  ALU result; address for rmmovq, mrmovq, call, pushq.
- M_valA  in  64  store data; address for ret and popq.
- M_dstE  in  4  destination register E, passed through.
- M_dstM  in  4  destination register M, passed through.
- m_stat  out  4  resulting status.
- m_icode  out  4  M_icode passed through.
- m_valE  out  64  M_valE passed through.
- m_valM  out  64  loaded data (registered).
- m_dstE  out  4  passed through.
- m_dstM  out  4  passed through.
- m_stall  out  1  high while an access is pending; hazard unit holds M and bubbles W.

Behaviour:
- Operation classes:
  - Read ops: icode 5 (mrmovq), 9 (ret), B (popq).
  - Write ops: icode 4 (rmmovq), 8 (call), A (pushq).
  - Every other icode is a non-memory op.
- Address selection: M_valA for icode 9 and B; M_valE otherwise.
  - The address is valid iff addr[2:0]==0 and addr < 8*DEPTH.
  - Word index is addr[.. :3].
- Access qualification: a mem op is "qualified" when M_stat==AOK and the address is valid.
- Status and pass-through:
  - Mem op with M_stat==AOK and invalid address: m_stat=ADR, no access, no stall.
  - Otherwise m_stat=M_stat.
  - Non-qualified instructions produce zero-stall, combinational pass-through.
- FSM states: IDLE, BUSY, DONE. Counter cnt is 4 bits.
  - IDLE: on a qualified op, m_stall=1, cnt←MEM_LAT-1, go to BUSY. Otherwise m_stall=0 and stay in IDLE.
  - BUSY: m_stall=1.
    - cnt!=0: decrement cnt.
    - cnt==0: on this edge, a write commits mem[idx]←M_valA, or a read loads valM_reg←mem[idx]; go to DONE.
  - DONE: m_stall=0, m_valM=valM_reg; go to IDLE unconditionally. The M register advances on this edge.
- Timing:
  - A qualified op holds M for MEM_LAT+2 cycles, of which MEM_LAT+1 are stall cycles.
  - Back-to-back mem ops each take the full sequence; DONE→IDLE sees the new instruction.
- m_valM:
  - Equals valM_reg in DONE.
  - Equals 0 in all other states.
  - Equals 0 for non-read ops.
- M inputs are required stable while m_stall=1; the block samples them only at edges.
- Reset:
  - Asynchronous; FSM←IDLE, cnt←0, valM_reg←0.
  - Memory contents are unaffected by reset.
  - Reset during BUSY aborts the access; no write commits.
  - After reset, outputs reflect the combinational pass-through of the M inputs with m_stall=0 and m_valM=0.
- Bubble input (M_icode=1, M_stat=AOK): no access, pass-through.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_rd (32 bits): increments on each read commit.
  - perf_wr (32 bits): increments on each write commit.
  - perf_stall (32 bits): increments on each cycle with m_stall=1.
  - All three clear on rst and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package y86_pkg holds:
  - icode constants: I_HALT=0, I_NOP=1, I_RMMOVQ=4, I_MRMOVQ=5, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B.
  - STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS.
  - mem_state_t enum.
- Sub-module dmem_array: DEPTH x 64 synchronous storage with single read/write port, we, idx, wdata, rdata; no reset.

Test Plan:
- rmmovq (icode 4) with M_valE=0x40, M_valA=0xDEADBEEF, MEM_LAT=2 → m_stall high for 3 cycles, then DONE; mem[8]=0xDEADBEEF.
- mrmovq (icode 5) with M_valE=0x40 after the preceding store → after 3 stall cycles, m_valM=0xDEADBEEF in DONE, m_stat=AOK.
- popq (icode B) with M_valA=0x43 (misaligned) → m_stat=ADR, m_stall=0 immediately, no memory change.
- Non-mem opq (icode 6) and bubble (icode 1) → m_stall never asserts; m_valE and m_dstE pass through unchanged in the same cycle.
- rst asserted in BUSY during a pushq to 0x80 → FSM returns to IDLE asynchronously, mem[16] keeps its prior value, m_stall=0.
- With DMEM_PERF_CNT_EN: one store plus one load at MEM_LAT=1 → perf_wr=1, perf_rd=1, perf_stall=4.
